adder64_rr_sched: RTL

//  Round-robin scheduler that shares one adder64 instance among NREQ requesters.
//  - Each cycle, grants at most one valid request and drives its A/B operands into adder64.
//  - Captures {id, S, C64} into an in-order response FIFO, drained by a single valid/ready consumer.
//  - Sits between the operand producers and the shared 64-bit adder datapath.

---
 rtl/adder64_rr_sched_pkg.sv | 18 +
 rtl/adder64.sv | 11 +
 rtl/adder64_rr_sched_rr_arb.sv | 47 ++++
 rtl/adder64_rr_sched.sv | 130 +++++++++++++
 4 files changed

// File: rtl/adder64_rr_sched_pkg.sv
// Shared definitions for the round-robin adder scheduler: datapath widths
// and the ceiling-log2 helper used to size ids and pointers.
package adder64_rr_sched_pkg;

    localparam int ADDER_W = 64;
    localparam int CNT_W   = 32;

    // Smallest r with 2**r >= n; evaluated at elaboration time for widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder64.sv
// Plain 64-bit adder: S = (A+B) mod 2^64, C64 = carry out of bit 63.
module adder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] s,
    output logic        c64
);

    assign {c64, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder64_rr_sched_rr_arb.sv
// Round-robin arbiter: grants the first valid requester at or after the
// priority pointer, then moves the pointer just past the winner.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant,
    output logic            grant_any,
    output logic [IDW-1:0]  grant_id
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] idx;
    logic           found;

    // Rotating scan from ptr; only the first hit is granted, so grant is one-hot or zero.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (en && !found && valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign grant_any = found;

    // Pointer advances past the winner; held when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/adder64_rr_sched.sv
// Shares one adder64 among NREQ requesters. One grant per cycle; the id,
// sum and carry of each granted operation go into an in-order response FIFO
// drained by a single valid/ready consumer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready never depends on rsp_* outputs other than through FIFO
// space, and requesters must not wait on req_ready before raising req_valid.
module adder64_rr_sched
    import adder64_rr_sched_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int RSP_DEPTH = 4,
    localparam int IDW       = clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [ADDER_W*NREQ-1:0] req_a,
    input  logic [ADDER_W*NREQ-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [ADDER_W-1:0]      rsp_sum,
    output logic                    rsp_c64,
    output logic [CNT_W-1:0]        op_count
);

    localparam int PW = clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = IDW + 1 + ADDER_W;

    logic [EW-1:0]      mem [RSP_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [EW-1:0]      head;
    logic [IDW-1:0]     last_id;
    logic [ADDER_W-1:0] last_sum;
    logic               last_c64;

    logic               space;
    logic               push;
    logic               pop;
    logic               grant_any;
    logic [IDW-1:0]     grant_id;
    logic [ADDER_W-1:0] op_a;
    logic [ADDER_W-1:0] op_b;
    logic [ADDER_W-1:0] sum;
    logic               c64;

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;
    // A pop in the same cycle frees the slot a push needs, even when full.
    assign space     = (count < CW'(RSP_DEPTH)) | pop;
    assign push      = grant_any;

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (space & ~rst),
        .valid     (req_valid),
        .grant     (req_ready),
        .grant_any (grant_any),
        .grant_id  (grant_id)
    );

    // Operand mux: granted requester's A/B, zeros when idle.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (grant_any) begin
            op_a = req_a[int'(grant_id)*ADDER_W +: ADDER_W];
            op_b = req_b[int'(grant_id)*ADDER_W +: ADDER_W];
        end
    end

    adder64 u_add (
        .a   (op_a),
        .b   (op_b),
        .s   (sum),
        .c64 (c64)
    );

    // Head entry is shown while non-empty; otherwise the last popped values.
    assign head    = mem[rd_ptr];
    assign rsp_id  = rsp_valid ? head[EW-1 -: IDW] : last_id;
    assign rsp_c64 = rsp_valid ? head[ADDER_W]     : last_c64;
    assign rsp_sum = rsp_valid ? head[ADDER_W-1:0] : last_sum;

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {grant_id, c64, sum};
        end
    end

    // FIFO pointers, occupancy, last-popped hold registers and delivery counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_id  <= '0;
            last_sum <= '0;
            last_c64 <= 1'b0;
            op_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_id  <= head[EW-1 -: IDW];
                last_c64 <= head[ADDER_W];
                last_sum <= head[ADDER_W-1:0];
                op_count <= op_count + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
